// File: rtl/glitcher_pkg.sv
// Shared types and default sizes for the form glitcher and its capture counterpart.
package glitcher_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam int FORM_WIDTH  = 64;
  localparam int DELAY_WIDTH = 64;

endpackage

// File: rtl/form_capture_deserializer.sv
// MSB-first shift-in register with bit counter; flags the shift that completes a word.
module deserializer
  import glitcher_pkg::*;
#(
  parameter int WIDTH = FORM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sample_in,
  output logic [WIDTH-1:0] word_next,
  output logic             full
);

  localparam int CNT_W = $clog2(WIDTH);

  // Only the previous WIDTH-1 samples need storing: the final sample joins them
  // combinationally on the completing shift.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    word_next = {shreg_q, sample_in};
    full      = shift_en && (cnt_q == CNT_W'(WIDTH - 1));
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    if (shift_en) begin
      shreg_d = word_next[WIDTH-2:0];
      cnt_d   = full ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/form_capture.sv
// Trigger-aligned serial capture: delay after a trig rising edge, deserialize
// WIDTH samples MSB-first, then hold the word on a valid/ready handshake.
module form_capture
  import glitcher_pkg::*;
#(
  parameter int WIDTH   = FORM_WIDTH,
  parameter int DELAY_W = DELAY_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               trig,
  input  logic [DELAY_W-1:0] delay,
  input  logic               sample_in,
  output logic [WIDTH-1:0]   data,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               missed
);

  capture_state_t     state_q, state_d;
  logic               trig_q;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               missed_q, missed_d;

  logic               trig_edge;
  logic               handshake;
  logic               shift_en;
  logic [WIDTH-1:0]   word_next;
  logic               full;

  assign trig_edge = trig & ~trig_q;
  assign handshake = valid_q & ready;
  assign shift_en  = (state_q == CAPTURE);

  deserializer #(
    .WIDTH(WIDTH)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .sample_in(sample_in),
    .word_next(word_next),
    .full     (full)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    missed_d = missed_q;
    case (state_q)
      IDLE: begin
        if (trig_edge && en) begin
          cnt_d   = delay;
          state_d = (delay != '0) ? DELAY : CAPTURE;
        end
      end
      DELAY: begin
        // Leaving at a count of 1 makes the first sample land exactly delay cycles later.
        if (cnt_q == DELAY_W'(1)) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      CAPTURE: begin
        if (full) begin
          data_d  = word_next;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (handshake) begin
          valid_d  = 1'b0;
          missed_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Applied after the handshake so a coincident edge still leaves missed set.
    if (trig_edge && (state_q != IDLE)) missed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      trig_q   <= 1'b1;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      missed_q <= missed_d;
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign busy   = (state_q != IDLE);
  assign missed = missed_q;

endmodule

// File: tb/tb_form_capture.sv
// Directed bench for form_capture: timing, handshake, re-trigger, gating, reset abort, loopback.
module tb_form_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        trig;
  logic [63:0] delay;
  logic        sample_in;
  logic [63:0] data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        missed;

  int total = 0;
  int fails = 0;

  form_capture dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .trig     (trig),
    .delay    (delay),
    .sample_in(sample_in),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .missed   (missed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after edge E (trig still high).
  task automatic start_trig();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
  endtask

  // Idles n cycles, then presents w MSB-first, one bit per cycle.
  // Returns just after the edge that takes the last sample.
  task automatic feed(input int n, input logic [63:0] w);
    repeat (n) tick();
    for (int k = 0; k < 64; k++) begin
      sample_in = w[63-k];
      tick();
    end
  endtask

  initial begin
    logic [63:0] w;
    rst = 1'b1; en = 1'b1; trig = 1'b1; delay = '0; sample_in = 1'b0; ready = 1'b0;
    #12;
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_missed", missed, 1'b0);
    check("rst_data", data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    check("trig_high_at_release_busy", busy, 1'b0);

    // Basic capture, delay=3
    delay = 64'd3;
    w = 64'hDEADBEEF_0123ABCD;
    start_trig();
    check("basic_busy_e1", busy, 1'b1);
    trig = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 64; k++) begin
      sample_in = w[63-k];
      tick();
      if (k == 62) check("basic_valid_early", valid, 1'b0);
    end
    check("basic_valid", valid, 1'b1);
    check("basic_data", data, 64'hDEADBEEF_0123ABCD);
    check("basic_busy_done", busy, 1'b1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("basic_valid_drop", valid, 1'b0);
    check("basic_busy_drop", busy, 1'b0);

    // Zero delay, stalled consumer
    delay = 64'd0;
    start_trig();
    trig = 1'b0;
    feed(0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("zd_valid", valid, 1'b1);
    repeat (10) tick();
    check("zd_valid_held", valid, 1'b1);
    check("zd_data_held", data, 64'hFFFF_FFFF_FFFF_FFFF);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("zd_valid_drop", valid, 1'b0);
    check("zd_idle", busy, 1'b0);

    // Re-trigger during DELAY and DONE
    delay = 64'd10;
    w = 64'h1234_5678_9ABC_DEF0;
    start_trig();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    check("rt_missed_delay", missed, 1'b1);
    trig = 1'b0;
    feed(8, w);
    check("rt_valid", valid, 1'b1);
    check("rt_data", data, w);
    trig = 1'b1;
    tick();
    check("rt_missed_done", missed, 1'b1);
    check("rt_data_done", data, w);
    trig = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("rt_missed_cleared", missed, 1'b0);
    repeat (3) tick();
    check("rt_no_second_capture", busy, 1'b0);

    // Gated and held trigger
    en = 1'b0;
    delay = 64'd0;
    start_trig();
    tick();
    check("gate_busy", busy, 1'b0);
    check("gate_missed", missed, 1'b0);
    en = 1'b1;
    tick(); tick();
    check("held_trig_busy", busy, 1'b0);
    start_trig();
    check("fresh_edge_busy", busy, 1'b1);
    trig = 1'b0;
    feed(0, 64'h0123_4567_89AB_CDEF);
    check("gate_data", data, 64'h0123_4567_89AB_CDEF);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Reset at sample 30 of CAPTURE
    delay = 64'd2;
    start_trig();
    repeat (2) tick();
    for (int k = 0; k < 30; k++) begin
      sample_in = k[0];
      tick();
    end
    rst = 1'b1;
    #2;
    check("arst_valid", valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_data", data, 64'd0);
    check("arst_missed", missed, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("arst_no_edge", busy, 1'b0);
    delay = 64'd1;
    start_trig();
    trig = 1'b0;
    feed(1, 64'hAAAA_AAAA_AAAA_AAAA);
    check("arst_recap_valid", valid, 1'b1);
    check("arst_recap_data", data, 64'hAAAA_AAAA_AAAA_AAAA);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Loopback from a glitcher serializing its form from E+1+delay
    delay = 64'd5;
    start_trig();
    trig = 1'b0;
    feed(5, 64'h8000_0000_0000_0001);
    check("loop_data", data, 64'h8000_0000_0000_0001);
    // Edge coincident with the accepting handshake
    trig = 1'b1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("coinc_missed", missed, 1'b1);
    check("coinc_valid", valid, 1'b0);
    tick();
    check("coinc_no_capture", busy, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/form_capture.md
# form_capture

Trigger-aligned serial capture block; the receive-side counterpart of the form glitcher. On a rising edge of `trig`, it waits a programmable number of `clk` cycles, then samples `sample_in` once per cycle into a WIDTH-bit word. It presents the result on a valid/ready handshake. It sits beside the glitcher on the same trigger and delay path, so a target response or a loopback of the glitch output can be recorded bit-exact.

## Interface
- `WIDTH`, 64: number of bits captured per trigger.
- `DELAY_W`, 64: width of the `delay` input.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  while low, triggers are ignored in IDLE; no effect on a capture in progress.
- `trig`  in  1  trigger level; a rising edge starts a capture.
- `delay`  in  DELAY_W  cycles between edge detection and the first sample; latched at edge detection.
- `sample_in`  in  1  serial data; already synchronous to `clk`.
- `data`  out  WIDTH  captured word; first sample at MSB (`data[WIDTH-1]`), last sample at LSB.
- `valid`  out  1  `data` holds a complete capture.
- `ready`  in  1  consumer accepts `data` when `valid & ready` at a clock edge.
- `busy`  out  1  high in DELAY, CAPTURE and DONE.
- `missed`  out  1  sticky; a trigger edge arrived while busy.

## Operation
- Edge detect: `trig_q` holds `trig` from the previous cycle. `trig_edge = trig & ~trig_q`. `trig_q` updates every cycle in all states.
- FSM states:
  - IDLE: on `trig_edge & en`, latch `delay` into the counter. Go to DELAY if `delay != 0`, else go to CAPTURE.
  - DELAY: decrement the counter each cycle. When it reaches 1, go to CAPTURE.
  - CAPTURE: shift left, `shreg <= {shreg[WIDTH-2:0], sample_in}`. The bit counter counts 0..WIDTH-1. On the WIDTH-th sample, copy the shift register into `data`, set `valid`, go to DONE.
  - DONE: hold `data` and `valid`. On `valid & ready`, clear `valid`, clear `missed`, go to IDLE.
- `trig_edge` outside IDLE is ignored and sets `missed`. If a trigger edge and the handshake fall on the same edge, the handshake clears `missed`, then the new edge sets it. The new edge does not start a capture.
- `trig_edge` in IDLE while `en` is low is ignored and does not set `missed`.
- Bit order is MSB-first, matching the glitcher serializer. A form looped back from the glitcher output to `sample_in` reproduces the same 64-bit word.
- Counter arithmetic is unsigned DELAY_W-bit. Do not wrap: the maximum delay `2^DELAY_W-1` is honoured exactly.

## Timing
- Let edge E be the first clock edge where `trig=1` and `trig_q=0`.
- Samples are taken at edges E+1+delay through E+delay+WIDTH.
- `valid` and `data` become visible after edge E+delay+WIDTH, so `valid` is first high in the following cycle.
- `delay=0` means the first sample is at E+1. Total trigger-to-valid latency is delay+WIDTH cycles after E.
- `valid` falls the cycle after the accepting edge. The earliest new trigger edge is accepted on the cycle after returning to IDLE.
- `data` is not changed until the next capture completes.
- Reset values:
  - FSM is IDLE.
  - `data=0`, `valid=0`, `busy=0`, `missed=0`, shift register 0, counters 0.
  - `trig_q=1`, so `trig` already high at reset release gives no edge.
- Reset asserted mid-capture aborts immediately; no partial word is ever presented.

## Structure
- Shared package `glitcher_pkg`:
  - `capture_state_t` enum (IDLE, DELAY, CAPTURE, DONE).
  - Default constants `FORM_WIDTH=64` and `DELAY_WIDTH=64`, shared with the glitcher.
- One sub-module, `deserializer`: a WIDTH-bit shift-in register with shift enable and bit counter, reporting `full` after WIDTH shifts.
- The FSM, delay counter, edge detect and handshake stay in `form_capture`.

## Test plan
- Basic capture: `delay=3`, drive `sample_in` with the bits of 64'hDEADBEEF_0123ABCD MSB-first starting at E+4. Require `valid` first high after E+67 and `data=64'hDEADBEEF_0123ABCD`. `busy` high from E+1 through the handshake.
- Zero delay, stalled consumer: `delay=0`, `sample_in` constant 1, `ready` held low for 10 cycles after `valid`. Require `data=64'hFFFF_FFFF_FFFF_FFFF` stable and `valid` held. After `ready` pulses, `valid` low the next cycle and FSM returns to IDLE.
- Re-trigger while busy: a second `trig` rising edge during DELAY and another during DONE. Require `missed=1` and the first capture unaffected. The handshake clears `missed`, and no second capture starts.
- Gated and held trigger: `en=0` with a trig edge gives `busy` staying 0 and `missed=0`. Then `trig` held high across `en` going 1 gives no capture; the next fresh rising edge does start one.
- Reset mid-capture: assert `rst` at sample 30 of CAPTURE. Require all outputs 0 immediately (asynchronous). After release, a fresh trigger with `delay=1` and alternating 1010… gives `data=64'hAAAA_AAAA_AAAA_AAAA`.
- Loopback: glitcher `out` wired to `sample_in`, both given the same `trig` and `delay=5`, form 64'h8000_0000_0000_0001. Require the captured word to equal the form.
